// File: rtl/buzzer_seq_if.sv
// Event/buzzer bundle between the workout FSM side and buzzer_seq.
//   Bu   : 2-bit event code (00 = none), Tick : timebase strobe
//   Bz   : buzzer enable, Busy : pattern playing
//   Code : code currently playing (00 idle), Pend : pending slot occupied
interface buzzer_seq_if;
   logic [1:0] Bu;
   logic       Tick;
   logic       Bz;
   logic       Busy;
   logic [1:0] Code;
   logic       Pend;

   modport master (output Bu, Tick, input  Bz, Busy, Code, Pend);
   modport slave  (input  Bu, Tick, output Bz, Busy, Code, Pend);
endinterface

// File: rtl/buzzer_seq.sv
// Turns 1-cycle buzzer event codes into beep patterns:
//   01 -> 1 beep, 10 -> 2 beeps, 11 -> 3 beeps with the last one long.
// One pending slot holds a later event; code 11 preempts anything else.
// Ports:
//   Clk : clock, rising edge
//   Re  : asynchronous active-low reset
//   bus : buzzer_seq_if.slave (Bu, Tick in; Bz, Busy, Code, Pend out)
module buzzer_seq #(
   parameter int unsigned ON_T   = 2,
   parameter int unsigned OFF_T  = 2,
   parameter int unsigned LONG_T = 6
) (
   input  logic         Clk,
   input  logic         Re,
   buzzer_seq_if.slave  bus
);

   localparam int unsigned TW = 4;

   // Timer reload values must fit the 4-bit counter and be nonzero
   if (ON_T < 1 || ON_T > 15 || OFF_T < 1 || OFF_T > 15 || LONG_T < 1 || LONG_T > 15) begin : g_param_chk
      $error("buzzer_seq: ON_T, OFF_T and LONG_T must be in 1..15");
   end

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tcnt_q,  tcnt_d;
   logic [1:0]    beeps_q, beeps_d;
   logic [1:0]    cur_q,   cur_d;
   logic [1:0]    pnd_q,   pnd_d;
   logic          bz_q, busy_q, pend_q;
   logic [1:0]    code_q;

   logic          do_start;
   logic [1:0]    start_code;
   logic          expire;
   logic [1:0]    winner;

   // State register; output flops are decoded from the next state so they
   // line up with the state they describe
   always_ff @(posedge Clk or negedge Re) begin
      if (!Re) begin
         state_q <= S_IDLE;
         tcnt_q  <= '0;
         beeps_q <= '0;
         cur_q   <= '0;
         pnd_q   <= '0;
         bz_q    <= 1'b0;
         busy_q  <= 1'b0;
         code_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         beeps_q <= beeps_d;
         cur_q   <= cur_d;
         pnd_q   <= pnd_d;
         bz_q    <= (state_d == S_ON);
         busy_q  <= (state_d != S_IDLE);
         code_q  <= cur_d;
         pend_q  <= (pnd_d != 2'b00);
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      beeps_d    = beeps_q;
      cur_d      = cur_q;
      pnd_d      = pnd_q;
      do_start   = 1'b0;
      start_code = 2'b00;
      winner     = 2'b00;
      // tcnt never reaches 0 while active, so "<= 1" is the expiry point
      expire     = bus.Tick && (tcnt_q <= TW'(1));

      case (state_q)
         S_IDLE: begin
            if (bus.Bu != 2'b00) begin
               do_start   = 1'b1;
               start_code = bus.Bu;
            end
         end
         default: begin
            if (bus.Bu == 2'b11 && cur_q != 2'b11) begin
               // Session done overrides whatever is playing or queued
               do_start   = 1'b1;
               start_code = 2'b11;
               pnd_d      = 2'b00;
            end else if (state_q == S_OFF && expire && beeps_q == 2'b00) begin
               // Pattern finished: the higher of incoming and pending plays next
               winner = (bus.Bu >= pnd_q) ? bus.Bu : pnd_q;
               pnd_d  = 2'b00;
               if (winner != 2'b00) begin
                  do_start   = 1'b1;
                  start_code = winner;
               end else begin
                  state_d = S_IDLE;
                  cur_d   = 2'b00;
                  tcnt_d  = '0;
               end
            end else begin
               if (bus.Bu != 2'b00 && bus.Bu >= pnd_q) begin
                  pnd_d = bus.Bu;
               end
               if (bus.Tick) begin
                  if (!expire) begin
                     tcnt_d = tcnt_q - TW'(1);
                  end else if (state_q == S_ON) begin
                     state_d = S_OFF;
                     tcnt_d  = TW'(OFF_T);
                     beeps_d = beeps_q - 2'(1);
                  end else begin
                     state_d = S_ON;
                     tcnt_d  = (cur_q == 2'b11 && beeps_q == 2'b01) ? TW'(LONG_T) : TW'(ON_T);
                  end
               end
            end
         end
      endcase

      // Beep count equals the code value; the first beep is never the long one
      if (do_start) begin
         state_d = S_ON;
         cur_d   = start_code;
         beeps_d = start_code;
         tcnt_d  = TW'(ON_T);
      end
   end

   assign bus.Bz   = bz_q;
   assign bus.Busy = busy_q;
   assign bus.Code = code_q;
   assign bus.Pend = pend_q;

endmodule

// File: tb/tb_buzzer_seq.sv
// Directed bench for buzzer_seq with ON_T=2, OFF_T=2, LONG_T=6.
module tb_buzzer_seq;

   logic clk;
   logic re;
   int   checks;
   int   failures;

   buzzer_seq_if bus ();

   buzzer_seq #(.ON_T(2), .OFF_T(2), .LONG_T(6)) dut (
      .Clk (clk),
      .Re  (re),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One scenario: up to three events, Tick=1 every cycle, expected waveforms
   typedef struct {
      int          id;
      int          e1_cyc;
      logic [1:0]  e1;
      int          e2_cyc;
      logic [1:0]  e2;
      int          e3_cyc;
      logic [1:0]  e3;
      logic [63:0] bz_mask;
      logic [63:0] pend_mask;
      int          sw_cyc;
      logic [1:0]  code_a;
      logic [1:0]  code_b;
      int          idle_cyc;
   } scen_t;

   scen_t scen [7];

   function automatic logic [63:0] rng(input int a, input int b);
      logic [63:0] m;
      m = '0;
      for (int i = a; i <= b; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      re       = 1'b0;
      bus.Bu   = 2'b00;
      bus.Tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      re = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_scen(input scen_t s);
      logic [1:0] ecode;
      logic       ebusy;
      do_reset();
      for (int c = 0; c <= s.idle_cyc + 1; c++) begin
         bus.Bu   = (c == s.e1_cyc) ? s.e1 :
                    (c == s.e2_cyc) ? s.e2 :
                    (c == s.e3_cyc) ? s.e3 : 2'b00;
         bus.Tick = 1'b1;
         @(negedge clk);
         ebusy = (c >= 1) && (c < s.idle_cyc);
         ecode = !ebusy ? 2'b00 : (c < s.sw_cyc) ? s.code_a : s.code_b;
         chk($sformatf("s%0d_bz", s.id),   c, 32'(bus.Bz),   32'(s.bz_mask[c]));
         chk($sformatf("s%0d_busy", s.id), c, 32'(bus.Busy), 32'(ebusy));
         chk($sformatf("s%0d_code", s.id), c, 32'(bus.Code), 32'(ecode));
         chk($sformatf("s%0d_pend", s.id), c, 32'(bus.Pend), 32'(s.pend_mask[c]));
         @(posedge clk);
         #1;
      end
      bus.Bu = 2'b00;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      re       = 1'b0;
      bus.Bu   = 2'b00;
      bus.Tick = 1'b0;

      // 1: single beep
      scen[0] = '{1, 0, 2'b01, -1, 2'b00, -1, 2'b00,
                  rng(1, 2), 64'd0, 99, 2'b01, 2'b01, 5};
      // 2: done pattern, last beep long
      scen[1] = '{2, 0, 2'b11, -1, 2'b00, -1, 2'b00,
                  rng(1, 2) | rng(5, 6) | rng(9, 14), 64'd0, 99, 2'b11, 2'b11, 17};
      // 3: skip then queued rest-over
      scen[2] = '{3, 0, 2'b10, 3, 2'b01, -1, 2'b00,
                  rng(1, 2) | rng(5, 6) | rng(9, 10), rng(4, 8), 9, 2'b10, 2'b01, 13};
      // 4: done preempts a playing rest-over
      scen[3] = '{4, 0, 2'b01, 2, 2'b11, -1, 2'b00,
                  rng(1, 4) | rng(7, 8) | rng(11, 16), 64'd0, 3, 2'b01, 2'b11, 19};
      // 5: lower-priority later event dropped, pending 10 kept
      scen[4] = '{5, 0, 2'b01, 2, 2'b10, 3, 2'b01,
                  rng(1, 2) | rng(5, 6) | rng(9, 10), rng(3, 4), 5, 2'b01, 2'b10, 13};
      // 6: event on the final-expiry edge beats a lower pending event
      scen[5] = '{6, 0, 2'b10, 3, 2'b01, 8, 2'b10,
                  rng(1, 2) | rng(5, 6) | rng(9, 10) | rng(13, 14), rng(4, 8), 9, 2'b10, 2'b10, 17};
      // 7: repeat of the current code is queued and replayed
      scen[6] = '{7, 0, 2'b11, 1, 2'b11, -1, 2'b00,
                  rng(1, 2) | rng(5, 6) | rng(9, 14) | rng(17, 18) | rng(21, 22) | rng(25, 30),
                  rng(2, 16), 99, 2'b11, 2'b11, 33};

      // Reset state
      #2;
      chk("rst_bz",   0, 32'(bus.Bz),   32'd0);
      chk("rst_busy", 0, 32'(bus.Busy), 32'd0);
      chk("rst_code", 0, 32'(bus.Code), 32'd0);
      chk("rst_pend", 0, 32'(bus.Pend), 32'd0);

      for (int i = 0; i < 7; i++) run_scen(scen[i]);

      // Asynchronous reset mid-pattern, Bu ignored while held
      do_reset();
      bus.Bu   = 2'b01;
      bus.Tick = 1'b1;
      @(posedge clk); #1;
      bus.Bu = 2'b00;
      @(posedge clk); #2;
      chk("ar_pre_bz", 2, 32'(bus.Bz), 32'd1);
      re = 1'b0;
      #1;
      chk("ar_bz",   2, 32'(bus.Bz),   32'd0);
      chk("ar_busy", 2, 32'(bus.Busy), 32'd0);
      chk("ar_code", 2, 32'(bus.Code), 32'd0);
      chk("ar_pend", 2, 32'(bus.Pend), 32'd0);
      bus.Bu = 2'b10;
      @(posedge clk); #1;
      bus.Bu = 2'b00;
      @(negedge clk);
      chk("ar_bu_busy", 3, 32'(bus.Busy), 32'd0);
      chk("ar_bu_code", 3, 32'(bus.Code), 32'd0);
      re = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("ar_rel_busy", 4, 32'(bus.Busy), 32'd0);
      chk("ar_rel_pend", 4, 32'(bus.Pend), 32'd0);

      // Tick=0 during ON freezes the beep
      do_reset();
      bus.Bu   = 2'b10;
      bus.Tick = 1'b1;
      @(posedge clk); #1;
      bus.Bu = 2'b00;
      for (int c = 1; c <= 8; c++) begin
         bus.Tick = (c >= 6);
         @(negedge clk);
         chk("th_bz",   c, 32'(bus.Bz),   32'(c <= 7));
         chk("th_busy", c, 32'(bus.Busy), 32'd1);
         chk("th_code", c, 32'(bus.Code), 32'd2);
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
